// File: rtl/mac_array.sv
// Lane-parallel multiply-accumulate engine: two-stage product/accumulate pipeline,
// then a quantised (shift, saturate, optional ReLU) result stream of n_cols beats.
module mac_array #(
    parameter int unsigned LANES   = 64,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 26,
    parameter int unsigned IDX_BIT = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [DATA_W-1:0]         x_data,
    input  logic [LANES*DATA_W-1:0]   w_data,
    input  logic [IDX_BIT-1:0]        n_cols,
    input  logic                      relu_en,
    input  logic [4:0]                shift,
    output logic                      mac_done,
    output logic                      out_valid,
    output logic [IDX_BIT-1:0]        out_idx,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_done,
    output logic                      busy
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PW = 2 * DATA_W;

    typedef enum logic [2:0] {IDLE, ACC, FLUSH, DRAIN, DONE} state_t;

    state_t                     state_q, state_d;
    logic                       flush_q, flush_d;
    logic [IDX_BIT-1:0]         n_lat_q, n_lat_d;
    logic                       relu_q, relu_d;
    logic [4:0]                 shift_q, shift_d;
    logic signed [PW-1:0]       prod_q [LANES];
    logic signed [PW-1:0]       prod_d [LANES];
    logic signed [ACC_W-1:0]    acc_q  [LANES];
    logic signed [ACC_W-1:0]    acc_d  [LANES];
    logic                       out_valid_q, out_valid_d;
    logic [IDX_BIT-1:0]         out_idx_q, out_idx_d;
    logic [DATA_W-1:0]          out_data_q, out_data_d;
    logic                       accept;
    logic                       last_idx;

    function automatic logic signed [PW-1:0] mul(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = {{DATA_W{a[DATA_W-1]}}, a};
        be = {{DATA_W{b[DATA_W-1]}}, b};
        return ae * be;
    endfunction

    function automatic logic [DATA_W-1:0] quant(input logic signed [ACC_W-1:0] a,
                                                input logic [4:0] sh,
                                                input logic relu);
        logic signed [ACC_W-1:0] q;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        logic [DATA_W-1:0]       r;
        hi = ACC_W'((2 ** (DATA_W - 1)) - 1);
        lo = ~hi;
        q  = a >>> sh;
        if (q > hi)      r = hi[DATA_W-1:0];
        else if (q < lo) r = lo[DATA_W-1:0];
        else             r = q[DATA_W-1:0];
        if (relu && r[DATA_W-1]) r = '0;
        return r;
    endfunction

    assign in_ready = (state_q == IDLE) || (state_q == ACC);
    assign accept   = in_valid && in_ready;
    assign last_idx = (out_idx_q == n_lat_q - IDX_BIT'(1));

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        n_lat_d = n_lat_q;
        relu_d  = relu_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    n_lat_d = ((n_cols == '0) || (n_cols > IDX_BIT'(LANES))) ? IDX_BIT'(LANES) : n_cols;
                    relu_d  = relu_en;
                    shift_d = shift;
                    state_d = in_last ? FLUSH : ACC;
                end
            end
            ACC: begin
                if (accept && in_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (flush_q) begin
                    flush_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    flush_d = 1'b1;
                end
            end
            DRAIN: begin
                if (last_idx) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The result for index i is read one cycle early so out_data lines up with out_valid.
    always_comb begin
        out_valid_d = 1'b0;
        out_idx_d   = '0;
        if ((state_q == FLUSH) && flush_q) begin
            out_valid_d = 1'b1;
        end else if ((state_q == DRAIN) && !last_idx) begin
            out_valid_d = 1'b1;
            out_idx_d   = out_idx_q + IDX_BIT'(1);
        end
        out_data_d = out_valid_d ? quant(acc_q[out_idx_d[LW-1:0]], shift_q, relu_q) : '0;
    end

    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            prod_d[k] = accept ? mul(x_data, w_data[k*DATA_W +: DATA_W]) : '0;
            acc_d[k]  = (state_q == DONE) ? '0
                      : acc_q[k] + {{(ACC_W-PW){prod_q[k][PW-1]}}, prod_q[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_q     <= 1'b0;
            n_lat_q     <= '0;
            relu_q      <= 1'b0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            n_lat_q     <= n_lat_d;
            relu_q      <= relu_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            for (int unsigned k = 0; k < LANES; k++) begin
                prod_q[k] <= prod_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    assign mac_done  = (state_q == DRAIN) && (out_idx_q == '0);
    assign out_done  = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array: hand-computed layers checked beat by beat against
// the cycle timing of the drain/result stream.
module tb_mac_array;

    localparam int unsigned LANES   = 64;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACC_W   = 26;
    localparam int unsigned IDX_BIT = 7;

    logic                     clk;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_last;
    logic [DATA_W-1:0]        x_data;
    logic [LANES*DATA_W-1:0]  w_data;
    logic [IDX_BIT-1:0]       n_cols;
    logic                     relu_en;
    logic [4:0]               shift;
    logic                     mac_done;
    logic                     out_valid;
    logic [IDX_BIT-1:0]       out_idx;
    logic [DATA_W-1:0]        out_data;
    logic                     out_done;
    logic                     busy;

    int unsigned total;
    int unsigned passes;
    int          exp_q [LANES];
    logic [LANES*DATA_W-1:0]  wv;

    mac_array #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .IDX_BIT(IDX_BIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .x_data   (x_data),
        .w_data   (w_data),
        .n_cols   (n_cols),
        .relu_en  (relu_en),
        .shift    (shift),
        .mac_done (mac_done),
        .out_valid(out_valid),
        .out_idx  (out_idx),
        .out_data (out_data),
        .out_done (out_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic cfg(input int n, input logic relu, input int sh);
        n_cols  = IDX_BIT'(n);
        relu_en = relu;
        shift   = 5'(sh);
    endtask

    task automatic beat(input int x, input logic [LANES*DATA_W-1:0] w, input logic last);
        in_valid = 1'b1;
        x_data   = 8'(x);
        w_data   = w;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [LANES*DATA_W-1:0] row4(input int a, input int b,
                                                     input int c, input int d);
        logic [LANES*DATA_W-1:0] r;
        r = '0;
        r[0*DATA_W +: DATA_W] = 8'(a);
        r[1*DATA_W +: DATA_W] = 8'(b);
        r[2*DATA_W +: DATA_W] = 8'(c);
        r[3*DATA_W +: DATA_W] = 8'(d);
        return r;
    endfunction

    // Called one cycle after the last beat edge (cycle T+1).
    task automatic drain(input int n, input string tag);
        check({tag, "_ready_flush"}, in_ready, 0);
        check({tag, "_busy_flush"}, busy, 1);
        check({tag, "_valid_flush"}, out_valid, 0);
        tick();
        tick();
        check({tag, "_mac_done"}, mac_done, 1);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, out_valid, 1);
            check({tag, "_idx"}, out_idx, i);
            check({tag, "_data"}, $signed(out_data), exp_q[i]);
            if (i == 1) check({tag, "_mac_done_once"}, mac_done, 0);
            check({tag, "_no_done_early"}, out_done, 0);
            tick();
        end
        check({tag, "_out_done"}, out_done, 1);
        check({tag, "_valid_end"}, out_valid, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check({tag, "_ready_after"}, in_ready, 1);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse"}, out_done, 0);
    endtask

    initial begin
        total    = 0;
        passes   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x_data   = '0;
        w_data   = '0;
        cfg(0, 1'b0, 0);
        tick();
        tick();
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx", out_idx, 0);
        check("rst_data", out_data, 0);
        check("rst_mac_done", mac_done, 0);
        check("rst_out_done", out_done, 0);
        rst = 1'b0;
        tick();

        // Basic accumulate: (2+3-1) * {1,2,3,4}
        cfg(4, 1'b0, 0);
        exp_q[0] = 4; exp_q[1] = 8; exp_q[2] = 12; exp_q[3] = 16;
        beat(2, row4(1, 2, 3, 4), 1'b0);
        beat(3, row4(1, 2, 3, 4), 1'b0);
        beat(-1, row4(1, 2, 3, 4), 1'b1);
        drain(4, "basic");

        // Same layer with junk beats held during FLUSH/DRAIN
        beat(2, row4(1, 2, 3, 4), 1'b0);
        beat(3, row4(1, 2, 3, 4), 1'b0);
        beat(-1, row4(1, 2, 3, 4), 1'b1);
        in_valid = 1'b1;
        x_data   = 8'd50;
        w_data   = {LANES{8'd50}};
        drain(4, "ignored");

        // n_cols=10: lane k weight k+1, x=1
        cfg(10, 1'b0, 0);
        for (int k = 0; k < int'(LANES); k++) begin
            wv[k*DATA_W +: DATA_W] = 8'(k + 1);
            exp_q[k] = k + 1;
        end
        beat(1, wv, 1'b1);
        drain(10, "ncols10");

        // n_cols=64: lane k weight k-32
        cfg(64, 1'b0, 0);
        for (int k = 0; k < int'(LANES); k++) begin
            wv[k*DATA_W +: DATA_W] = 8'(k - 32);
            exp_q[k] = k - 32;
        end
        beat(1, wv, 1'b1);
        drain(64, "ncols64");

        // Saturation and ReLU
        cfg(1, 1'b0, 0);
        exp_q[0] = 127;
        beat(127, row4(127, 0, 0, 0), 1'b1);
        drain(1, "sat_pos");
        exp_q[0] = -128;
        beat(-128, row4(127, 0, 0, 0), 1'b1);
        drain(1, "sat_neg");
        cfg(1, 1'b1, 0);
        exp_q[0] = 0;
        beat(-128, row4(127, 0, 0, 0), 1'b1);
        drain(1, "relu");

        // Shift
        cfg(1, 1'b0, 3);
        exp_q[0] = 125;
        beat(100, row4(10, 0, 0, 0), 1'b1);
        drain(1, "shift3");
        cfg(1, 1'b0, 1);
        exp_q[0] = -5;
        beat(-9, row4(1, 0, 0, 0), 1'b1);
        drain(1, "shift_neg");

        // Full layer: 784 * 16384 = 12845056, >>>17 = 98
        cfg(0, 1'b0, 17);
        for (int k = 0; k < int'(LANES); k++) exp_q[k] = 98;
        for (int i = 0; i < 784; i++) beat(-128, {LANES{8'h80}}, (i == 783));
        drain(64, "full");

        // Reset during the 5th DRAIN cycle
        cfg(8, 1'b0, 0);
        for (int k = 0; k < int'(LANES); k++) wv[k*DATA_W +: DATA_W] = 8'(k + 1);
        beat(1, wv, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check("mid_valid_before", out_valid, 1);
        check("mid_idx_before", out_idx, 4);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_done", out_done, 0);
        check("mid_rst_data", out_data, 0);
        rst = 1'b0;
        tick();
        check("post_rst_done", out_done, 0);
        check("post_rst_valid", out_valid, 0);
        cfg(1, 1'b0, 0);
        exp_q[0] = 1;
        beat(1, row4(1, 0, 0, 0), 1'b1);
        drain(1, "after_rst");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
